// File: rtl/csr_file_mp.sv
// Multi-port machine-mode CSR file for RV64IM. It has prioritised write channels, combinational
// read ports with optional write bypass, free-running counters and atomic trap/mret updates.
module csr_file_mp #(
  parameter int XLEN    = 64,
  parameter int CSR_W   = 3,
  parameter int CSR_NUM = 8,
  parameter int NW      = 2,
  parameter int NR      = 2,
  parameter int RET_W   = 2,
  parameter int BYPASS  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NR*CSR_W-1:0]   rd_idx,
  output logic [NR*XLEN-1:0]    rd_data,
  input  logic [NW-1:0]         wr_en,
  input  logic [NW*CSR_W-1:0]   wr_idx,
  input  logic [NW*XLEN-1:0]    wr_data,
  input  logic                  trap_valid,
  input  logic [XLEN-1:0]       trap_pc,
  input  logic [XLEN-1:0]       trap_cause,
  input  logic                  mret_valid,
  input  logic [RET_W-1:0]      retire_cnt,
  output logic [XLEN-1:0]       mtvec_o,
  output logic [XLEN-1:0]       mepc_o
);

  localparam int IDX_MSTATUS   = 0;
  localparam int IDX_MTVEC     = 1;
  localparam int IDX_MEPC      = 2;
  localparam int IDX_MCAUSE    = 3;
  localparam int IDX_MVENDORID = 4;
  localparam int IDX_MARCHID   = 5;
  localparam int IDX_MCYCLE    = 6;
  localparam int IDX_MINSTRET  = 7;

  localparam int MIE_BIT  = 3;
  localparam int MPIE_BIT = 7;

  function automatic logic [XLEN-1:0] reset_value(input int idx);
    logic [XLEN-1:0] v;
    case (idx)
      IDX_MSTATUS:   v = XLEN'(64'h0000_000a_0000_1800);
      IDX_MVENDORID: v = XLEN'(64'h7973_7978_015F_DEA8);
      IDX_MARCHID:   v = XLEN'(64'h4C4A_5100_0CA0_E255);
      default:       v = '0;
    endcase
    return v;
  endfunction

  logic [XLEN-1:0]    csr_q   [CSR_NUM];
  logic [XLEN-1:0]    csr_d   [CSR_NUM];
  logic [XLEN-1:0]    wr_val  [CSR_NUM];
  logic [CSR_NUM-1:0] wr_hit;
  logic [CSR_NUM-1:0] wr_ok;
  logic [XLEN-1:0]    mstatus_trap;
  logic [XLEN-1:0]    mstatus_mret;

  // Per-CSR winning write: scanning channels downward lets the lowest channel overwrite.
  always_comb begin
    // NOTE: every combinational output gets a default before any conditional assignment,
    // so no path leaves a value held and no latch is inferred.
    for (int i = 0; i < CSR_NUM; i++) begin
      wr_hit[i] = 1'b0;
      wr_val[i] = '0;
      for (int c = NW - 1; c >= 0; c--) begin
        if (wr_en[c] && (int'(wr_idx[c*CSR_W +: CSR_W]) == i)) begin
          wr_hit[i] = 1'b1;
          wr_val[i] = wr_data[c*XLEN +: XLEN];
        end
      end
    end
  end

  // A write lands only if the CSR is writable and no trap/mret owns it this cycle.
  always_comb begin
    for (int i = 0; i < CSR_NUM; i++) begin
      wr_ok[i] = wr_hit[i];
      if (i == IDX_MVENDORID || i == IDX_MARCHID) wr_ok[i] = 1'b0;
      if (trap_valid && (i == IDX_MSTATUS || i == IDX_MEPC || i == IDX_MCAUSE)) wr_ok[i] = 1'b0;
      if (mret_valid && i == IDX_MSTATUS) wr_ok[i] = 1'b0;
    end
  end

  always_comb begin
    mstatus_trap              = csr_q[IDX_MSTATUS];
    mstatus_trap[MPIE_BIT]    = csr_q[IDX_MSTATUS][MIE_BIT];
    mstatus_trap[MIE_BIT]     = 1'b0;
    mstatus_trap[12:11]       = 2'b11;

    mstatus_mret              = csr_q[IDX_MSTATUS];
    mstatus_mret[MIE_BIT]     = csr_q[IDX_MSTATUS][MPIE_BIT];
    mstatus_mret[MPIE_BIT]    = 1'b1;
    mstatus_mret[12:11]       = 2'b11;
  end

  // Later assignments override earlier ones, giving trap > mret > write > increment.
  always_comb begin
    for (int i = 0; i < CSR_NUM; i++) csr_d[i] = csr_q[i];
    csr_d[IDX_MCYCLE]   = csr_q[IDX_MCYCLE] + XLEN'(1);
    csr_d[IDX_MINSTRET] = csr_q[IDX_MINSTRET] + XLEN'(retire_cnt);
    for (int i = 0; i < CSR_NUM; i++) begin
      if (wr_ok[i]) csr_d[i] = wr_val[i];
    end
    if (trap_valid) begin
      csr_d[IDX_MSTATUS] = mstatus_trap;
      csr_d[IDX_MEPC]    = trap_pc;
      csr_d[IDX_MCAUSE]  = trap_cause;
    end else if (mret_valid) begin
      csr_d[IDX_MSTATUS] = mstatus_mret;
    end
  end

  // NOTE: the CSR array is a handful of flops, not a RAM, so it takes the async reset like
  // any other state; the reset value is in place as soon as rst rises, before any clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CSR_NUM; i++) csr_q[i] <= reset_value(i);
    end else begin
      for (int i = 0; i < CSR_NUM; i++) csr_q[i] <= csr_d[i];
    end
  end

  for (genvar r = 0; r < NR; r++) begin : g_rd
    logic [CSR_W-1:0] sel;
    logic [XLEN-1:0]  val;

    assign sel = rd_idx[r*CSR_W +: CSR_W];

    always_comb begin
      val = '0;
      if (int'(sel) < CSR_NUM) begin
        if (BYPASS != 0 && wr_ok[sel]) val = wr_val[sel];
        else                           val = csr_q[sel];
      end
    end

    assign rd_data[r*XLEN +: XLEN] = val;
  end

  assign mtvec_o = csr_q[IDX_MTVEC];
  assign mepc_o  = csr_q[IDX_MEPC];

endmodule

// File: tb/tb_csr_file_mp.sv
// Self-checking bench for csr_file_mp. It uses directed scenarios plus random traffic,
// all checked against a behavioural model of the CSR rules.
module tb_csr_file_mp;

  localparam int XLEN  = 64;
  localparam int CSR_W = 3;
  localparam int NW    = 2;
  localparam int NR    = 2;
  localparam int RET_W = 2;

  localparam logic [63:0] MSTATUS_RST = 64'h0000_000a_0000_1800;
  localparam logic [63:0] MVENDOR_RST = 64'h7973_7978_015F_DEA8;
  localparam logic [63:0] MARCH_RST   = 64'h4C4A_5100_0CA0_E255;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NR*CSR_W-1:0]   rd_idx;
  logic [NR*XLEN-1:0]    rd_data;
  logic [NW-1:0]         wr_en;
  logic [NW*CSR_W-1:0]   wr_idx;
  logic [NW*XLEN-1:0]    wr_data;
  logic                  trap_valid;
  logic [XLEN-1:0]       trap_pc;
  logic [XLEN-1:0]       trap_cause;
  logic                  mret_valid;
  logic [RET_W-1:0]      retire_cnt;
  logic [XLEN-1:0]       mtvec_o;
  logic [XLEN-1:0]       mepc_o;

  int checks = 0;
  int errors = 0;

  logic [63:0] m [8];

  always #10 clk = ~clk;

  csr_file_mp #(
    .XLEN(XLEN), .CSR_W(CSR_W), .CSR_NUM(8), .NW(NW), .NR(NR), .RET_W(RET_W), .BYPASS(1)
  ) dut (
    .clk(clk), .rst(rst), .rd_idx(rd_idx), .rd_data(rd_data),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
    .trap_valid(trap_valid), .trap_pc(trap_pc), .trap_cause(trap_cause),
    .mret_valid(mret_valid), .retire_cnt(retire_cnt),
    .mtvec_o(mtvec_o), .mepc_o(mepc_o)
  );

  function automatic logic [63:0] reset_val(input int i);
    case (i)
      0:       return MSTATUS_RST;
      4:       return MVENDOR_RST;
      5:       return MARCH_RST;
      default: return 64'h0;
    endcase
  endfunction

  function automatic bit writable(input int i);
    if (i == 4 || i == 5) return 1'b0;
    if (trap_valid && (i == 0 || i == 2 || i == 3)) return 1'b0;
    if (mret_valid && i == 0) return 1'b0;
    return 1'b1;
  endfunction

  // First (lowest-numbered) channel addressing CSR i, if that write is allowed to land.
  function automatic bit write_wins(input int i, output logic [63:0] data);
    data = 64'h0;
    for (int c = 0; c < NW; c++) begin
      if (wr_en[c] && int'(wr_idx[c*CSR_W +: CSR_W]) == i) begin
        data = wr_data[c*XLEN +: XLEN];
        return writable(i);
      end
    end
    return 1'b0;
  endfunction

  function automatic logic [63:0] exp_read(input int i);
    logic [63:0] d;
    if (write_wins(i, d)) return d;
    return m[i];
  endfunction

  task automatic clear_inputs();
    wr_en = '0; wr_idx = '0; wr_data = '0;
    trap_valid = 1'b0; trap_pc = '0; trap_cause = '0;
    mret_valid = 1'b0; retire_cnt = '0;
  endtask

  // Advance one clock edge, updating the model from the inputs held across that edge.
  task automatic tick();
    logic [63:0] nx [8];
    logic [63:0] d;
    logic [63:0] s;
    for (int i = 0; i < 8; i++) nx[i] = m[i];
    nx[6] = m[6] + 64'd1;
    nx[7] = m[7] + 64'(retire_cnt);
    for (int i = 0; i < 8; i++) if (write_wins(i, d)) nx[i] = d;
    s = m[0];
    if (trap_valid) begin
      nx[2] = trap_pc;
      nx[3] = trap_cause;
      s[7] = m[0][3]; s[3] = 1'b0; s[12:11] = 2'b11;
      nx[0] = s;
    end else if (mret_valid) begin
      s[3] = m[0][7]; s[7] = 1'b1; s[12:11] = 2'b11;
      nx[0] = s;
    end
    if (rst) for (int i = 0; i < 8; i++) nx[i] = reset_val(i);
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) m[i] = nx[i];
  endtask

  task automatic wr0(input int idx, input logic [63:0] data);
    wr_en = 2'b01;
    wr_idx = {3'd0, 3'(idx)};
    wr_data = {64'h0, data};
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    rd_idx = '0;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i += 2) begin
      rd_idx = {3'(i + 1), 3'(i)};
      #1;
      checks++;
      if (rd_data[63:0] !== reset_val(i)) begin
        errors++; $display("FAIL reset_read idx%0d: got %h want %h", i, rd_data[63:0], reset_val(i));
      end
      checks++;
      if (rd_data[127:64] !== reset_val(i + 1)) begin
        errors++; $display("FAIL reset_read idx%0d: got %h want %h", i + 1, rd_data[127:64], reset_val(i + 1));
      end
    end
    tick();
    rd_idx = {3'd0, 3'd6};
    #1;
    checks++;
    if (rd_data[63:0] !== 64'd1) begin
      errors++; $display("FAIL reset_mcycle_first: got %h want %h", rd_data[63:0], 64'd1);
    end
    wr0(4, 64'h5);
    tick();
    clear_inputs();
    rd_idx = {3'd0, 3'd4};
    #1;
    checks++;
    if (rd_data[63:0] !== MVENDOR_RST) begin
      errors++; $display("FAIL mvendorid_ro: got %h want %h", rd_data[63:0], MVENDOR_RST);
    end
  endtask

  task automatic test_write_priority();
    wr_en = 2'b11;
    wr_idx = {3'd2, 3'd2};
    wr_data = {64'hBBBB, 64'hAAAA};
    rd_idx = {3'd2, 3'd0};
    #1;
    checks++;
    if (rd_data[127:64] !== 64'hAAAA) begin
      errors++; $display("FAIL bypass_priority: got %h want %h", rd_data[127:64], 64'hAAAA);
    end
    tick();
    clear_inputs();
    #1;
    checks++;
    if (mepc_o !== 64'hAAAA) begin
      errors++; $display("FAIL write_priority: got %h want %h", mepc_o, 64'hAAAA);
    end
  endtask

  task automatic test_trap();
    wr0(0, 64'ha00001808);
    tick();
    clear_inputs();
    trap_valid = 1'b1;
    trap_pc = 64'h80000100;
    trap_cause = 64'hB;
    wr0(2, 64'h1234);
    tick();
    clear_inputs();
    rd_idx = {3'd0, 3'd3};
    #1;
    checks++;
    if (mepc_o !== 64'h80000100) begin
      errors++; $display("FAIL trap_mepc: got %h want %h", mepc_o, 64'h80000100);
    end
    checks++;
    if (rd_data[63:0] !== 64'hB) begin
      errors++; $display("FAIL trap_mcause: got %h want %h", rd_data[63:0], 64'hB);
    end
    checks++;
    if (rd_data[127:64] !== 64'ha00001880) begin
      errors++; $display("FAIL trap_mstatus: got %h want %h", rd_data[127:64], 64'ha00001880);
    end
  endtask

  task automatic test_mret();
    mret_valid = 1'b1;
    tick();
    clear_inputs();
    rd_idx = {3'd0, 3'd0};
    #1;
    checks++;
    if (rd_data[63:0] !== 64'ha00001888) begin
      errors++; $display("FAIL mret_mstatus: got %h want %h", rd_data[63:0], 64'ha00001888);
    end
    trap_valid = 1'b1;
    mret_valid = 1'b1;
    trap_pc = 64'h80000200;
    trap_cause = 64'h7;
    tick();
    clear_inputs();
    #1;
    checks++;
    if (rd_data[63:0] !== 64'ha00001880) begin
      errors++; $display("FAIL trap_over_mret_mstatus: got %h want %h", rd_data[63:0], 64'ha00001880);
    end
    checks++;
    if (mepc_o !== 64'h80000200) begin
      errors++; $display("FAIL trap_over_mret_mepc: got %h want %h", mepc_o, 64'h80000200);
    end
  endtask

  task automatic test_counters();
    wr0(7, 64'h0);
    retire_cnt = 2'd3;
    tick();
    wr_en = '0;
    repeat (4) tick();
    retire_cnt = 2'd0;
    rd_idx = {3'd6, 3'd7};
    #1;
    checks++;
    if (rd_data[63:0] !== 64'd12) begin
      errors++; $display("FAIL minstret_accum: got %h want %h", rd_data[63:0], 64'd12);
    end
    wr0(7, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    clear_inputs();
    retire_cnt = 2'd2;
    tick();
    retire_cnt = 2'd0;
    #1;
    checks++;
    if (rd_data[63:0] !== 64'd1) begin
      errors++; $display("FAIL minstret_wrap: got %h want %h", rd_data[63:0], 64'd1);
    end
    wr0(6, 64'h100);
    tick();
    clear_inputs();
    #1;
    checks++;
    if (rd_data[127:64] !== 64'h100) begin
      errors++; $display("FAIL mcycle_write: got %h want %h", rd_data[127:64], 64'h100);
    end
    tick();
    #1;
    checks++;
    if (rd_data[127:64] !== 64'h101) begin
      errors++; $display("FAIL mcycle_incr: got %h want %h", rd_data[127:64], 64'h101);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      wr_en = 2'($urandom_range(0, 3));
      wr_idx = 6'($urandom);
      if ($urandom_range(0, 3) == 0) wr_idx[5:3] = wr_idx[2:0];
      wr_data = {$urandom, $urandom, $urandom, $urandom};
      trap_valid = ($urandom_range(0, 9) == 0);
      mret_valid = ($urandom_range(0, 7) == 0);
      trap_pc = {$urandom, $urandom};
      trap_cause = 64'($urandom_range(0, 15));
      retire_cnt = 2'($urandom);
      rd_idx = 6'($urandom);
      #2;
      for (int p = 0; p < NR; p++) begin
        checks++;
        if (rd_data[p*64 +: 64] !== exp_read(int'(rd_idx[p*3 +: 3]))) begin
          errors++;
          $display("FAIL random_read cycle%0d port%0d idx%0d: got %h want %h", n, p,
                   rd_idx[p*3 +: 3], rd_data[p*64 +: 64], exp_read(int'(rd_idx[p*3 +: 3])));
        end
      end
      checks++;
      if (mtvec_o !== m[1] || mepc_o !== m[2]) begin
        errors++; $display("FAIL random_outs cycle%0d: got %h/%h want %h/%h", n, mtvec_o, mepc_o, m[1], m[2]);
      end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_async_reset();
    wr0(1, 64'h1000);
    tick();
    clear_inputs();
    #1;
    checks++;
    if (mtvec_o !== 64'h1000) begin
      errors++; $display("FAIL pre_reset_mtvec: got %h want %h", mtvec_o, 64'h1000);
    end
    wr_en = 2'b11;
    wr_idx = {3'd2, 3'd1};
    wr_data = {64'hBEEF, 64'hDEAD};
    retire_cnt = 2'd3;
    rd_idx = {3'd7, 3'd6};
    #3;
    rst = 1'b1;
    #1;
    for (int i = 0; i < 8; i++) m[i] = reset_val(i);
    checks++;
    if (mtvec_o !== 64'h0 || mepc_o !== 64'h0) begin
      errors++; $display("FAIL async_reset_outs: got %h/%h want 0/0", mtvec_o, mepc_o);
    end
    checks++;
    if (rd_data !== 128'h0) begin
      errors++; $display("FAIL async_reset_counters: got %h want 0", rd_data);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_inputs();
    #1;
    checks++;
    if (mtvec_o !== 64'h0 || rd_data[63:0] !== 64'h0) begin
      errors++; $display("FAIL reset_write_dropped: got %h/%h want 0/0", mtvec_o, rd_data[63:0]);
    end
    tick();
    #1;
    checks++;
    if (rd_data[63:0] !== 64'd1 || rd_data[63:0] !== m[6]) begin
      errors++; $display("FAIL post_reset_mcycle: got %h want %h", rd_data[63:0], 64'd1);
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) m[i] = 64'h0;
    test_reset();
    test_write_priority();
    test_trap();
    test_mret();
    test_counters();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
